expr_result_compactor: RTL and testbench

EXPR_RESULT_COMPACTOR -- requirements
Module: expr_result_compactor

---
 rtl/expr_compact_pkg.sv | 24 ++
 rtl/expr_misr32.sv | 34 +++
 rtl/expr_result_compactor.sv | 131 +++++++++++++
 tb/tb_expr_result_compactor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_compact_pkg.sv
// Shared definitions for the expression-result compactor.
// Contents: FSM state enum, MISR polynomial and seed, and the 90-to-32 bit
// fold applied to every accepted expression result.
package expr_compact_pkg;

  localparam int unsigned SIG_W  = 32;
  localparam int unsigned FOLD_W = 90;

  localparam logic [SIG_W-1:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [SIG_W-1:0] MISR_SEED = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // XOR the low two 32-bit words with the zero-extended 26-bit top slice.
  function automatic logic [SIG_W-1:0] fold90(input logic [FOLD_W-1:0] y);
    return y[31:0] ^ y[63:32] ^ {6'd0, y[89:64]};
  endfunction

endpackage

// File: rtl/expr_misr32.sv
// 32-bit multiple-input signature register (CRC-32 polynomial feedback).
// Ports: clk, reset (sync, active-high, clears sig to 0),
//        load_seed (sig <= seed), enable (fold din into sig), din[31:0],
//        sig[31:0] (registered signature).
// Priority: reset > load_seed > enable.
module expr_misr32
  import expr_compact_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_seed,
  input  logic        enable,
  input  logic [31:0] din,
  output logic [31:0] sig
);

  logic [31:0] next_sig_c;

  // Shift left, apply polynomial feedback on the outgoing MSB, then mix in data.
  always_comb begin
    next_sig_c = {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig <= 32'h0;
    end else if (load_seed) begin
      sig <= MISR_SEED;
    end else if (enable) begin
      sig <= next_sig_c;
    end
  end

endmodule

// File: rtl/expr_result_compactor.sv
// Compacts a stream of expression results into a 32-bit MISR signature and
// compares it against a golden value after num_vectors accepts.
// Ports: clk, reset (sync, active-high); start, num_vectors, expected_sig
//        (sampled on start); in_valid/in_ready/in_y upstream handshake;
//        busy, done, pass, signature, vec_count status (all registered).
// Optional: define EXPR_RESULT_CAPTURE_EN to add first_y/last_y capture
//        outputs holding the first and most recent accepted in_y of a run.
module expr_result_compactor
  import expr_compact_pkg::*;
#(
  parameter int unsigned Y_WIDTH   = 90,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_vectors,
  input  logic [31:0]          expected_sig,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Y_WIDTH-1:0]   in_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [31:0]          signature,
  output logic [CNT_WIDTH-1:0] vec_count
`ifdef EXPR_RESULT_CAPTURE_EN
  ,
  output logic [Y_WIDTH-1:0]   first_y,
  output logic [Y_WIDTH-1:0]   last_y
`endif
);

  state_t               state;
  logic [CNT_WIDTH-1:0] num_lat;
  logic [31:0]          exp_lat;

  logic                 accept_c;
  logic                 start_c;
  logic                 last_c;
  logic [31:0]          fold_c;

  // start only takes effect from an idle/finished state.
  always_comb begin
    accept_c = in_valid && in_ready;
    start_c  = start && ((state == IDLE) || (state == DONE));
    last_c   = accept_c && ((vec_count + CNT_WIDTH'(1)) == num_lat);
    fold_c   = fold90(FOLD_W'(in_y));
  end

  expr_misr32 u_misr (
    .clk       (clk),
    .reset     (reset),
    .load_seed (start_c),
    .enable    (accept_c),
    .din       (fold_c),
    .sig       (signature)
  );

  // Control FSM; in_ready and busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      vec_count <= '0;
      num_lat   <= '0;
      exp_lat   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_lat   <= num_vectors;
            exp_lat   <= expected_sig;
            vec_count <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            if (num_vectors == '0) begin
              state <= FINAL;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept_c) begin
            vec_count <= vec_count + CNT_WIDTH'(1);
          end
          if (last_c) begin
            state    <= FINAL;
            in_ready <= 1'b0;
          end
        end
        FINAL: begin
          // Signature is final here: no accepts occur outside RUN.
          pass  <= (signature == exp_lat);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXPR_RESULT_CAPTURE_EN
  // vec_count==0 marks the first accept of a run.
  always_ff @(posedge clk) begin
    if (reset || start_c) begin
      first_y <= '0;
      last_y  <= '0;
    end else if (accept_c) begin
      if (vec_count == '0) begin
        first_y <= in_y;
      end
      last_y <= in_y;
    end
  end
`else
  // Capture registers are not built in this configuration.
`endif

endmodule

// File: tb/tb_expr_result_compactor.sv
// Directed self-checking bench for expr_result_compactor.
module tb_expr_result_compactor;

  localparam int unsigned Y_WIDTH   = 90;
  localparam int unsigned CNT_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [CNT_WIDTH-1:0] num_vectors;
  logic [31:0]          expected_sig;
  logic                 in_valid;
  logic                 in_ready;
  logic [Y_WIDTH-1:0]   in_y;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [31:0]          signature;
  logic [CNT_WIDTH-1:0] vec_count;
`ifdef EXPR_RESULT_CAPTURE_EN
  logic [Y_WIDTH-1:0]   first_y;
  logic [Y_WIDTH-1:0]   last_y;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  expr_result_compactor #(.Y_WIDTH(Y_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_vectors  (num_vectors),
    .expected_sig (expected_sig),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_y         (in_y),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature),
    .vec_count    (vec_count)
`ifdef EXPR_RESULT_CAPTURE_EN
    ,
    .first_y      (first_y),
    .last_y       (last_y)
`endif
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference signature step written straight from the algorithm description.
  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [89:0] y);
    logic [31:0] f;
    logic [31:0] sh;
    f  = y[31:0] ^ y[63:32] ^ {6'd0, y[89:64]};
    sh = s << 1;
    if (s[31]) sh = sh ^ 32'h04C11DB7;
    return sh ^ f;
  endfunction

  task automatic do_start(input logic [CNT_WIDTH-1:0] nv, input logic [31:0] es);
    start        = 1'b1;
    num_vectors  = nv;
    expected_sig = es;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) check({tag, "_timeout"}, 128'(done), 128'(1));
  endtask

  logic [89:0] gap_vals [7];
  int          gap_pat  [7];
  logic [31:0] model;
  int          accepts;
  logic [89:0] ya, yb;

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    num_vectors  = '0;
    expected_sig = '0;
    in_valid     = 1'b0;
    in_y         = '0;
    gap_vals[0] = 90'h1234_5678_9ABC_DEF0_1357_246;
    gap_vals[1] = 90'h3FF_FFFF_FFFF_FFFF_FFFF_FFFF;
    gap_vals[2] = 90'h2AA_AAAA_AAAA_AAAA_AAAA_AAAA;
    gap_vals[3] = 90'h000_0000_0000_0000_DEAD_BEEF;
    gap_vals[4] = 90'h155_5555_0000_0001_8000_0000;
    gap_vals[5] = 90'h0F0_F0F0_F0F0_F0F0_F0F0_F0F0;
    gap_vals[6] = 90'h001_0000_0002_0000_0003_0004;
    gap_pat = '{1, 0, 0, 1, 1, 0, 1};

    // Reset together with start: reset wins.
    start = 1'b1;
    num_vectors = 16'd3;
    tick(2);
    start = 1'b0;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ready", 128'(in_ready), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_pass", 128'(pass), 128'(0));
    check("rst_sig", 128'(signature), 128'(0));
    check("rst_cnt", 128'(vec_count), 128'(0));
    reset = 1'b0;
    tick();

    // Reset held 2 cycles while in RUN.
    do_start(16'd3, 32'h0);
    check("run_busy", 128'(busy), 128'(1));
    check("run_seed", 128'(signature), 128'(32'hFFFFFFFF));
    in_valid = 1'b1;
    in_y     = gap_vals[0];
    tick();
    in_valid = 1'b0;
    check("run_cnt1", 128'(vec_count), 128'(1));
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rrun_ready", 128'(in_ready), 128'(0));
    check("rrun_busy", 128'(busy), 128'(0));
    check("rrun_sig", 128'(signature), 128'(0));
    check("rrun_cnt", 128'(vec_count), 128'(0));
    check("rrun_done", 128'(done), 128'(0));

    // Single zero vector: FFFFFFFE ^ 04C11DB7 = FB3EE249.
    do_start(16'd1, 32'hFB3EE249);
    in_valid = 1'b1;
    in_y     = '0;
    check("one_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    check("one_ready_off", 128'(in_ready), 128'(0));
    wait_done("one", 10);
    check("one_sig", 128'(signature), 128'(32'hFB3EE249));
    check("one_cnt", 128'(vec_count), 128'(1));
    check("one_done", 128'(done), 128'(1));
    check("one_pass", 128'(pass), 128'(1));
    check("one_busy", 128'(busy), 128'(0));
    tick(3);
    check("one_hold_sig", 128'(signature), 128'(32'hFB3EE249));
    check("one_hold_done", 128'(done), 128'(1));

    // Zero vectors: done exactly two edges after start.
    do_start(16'd0, 32'hFFFFFFFF);
    check("zero_ready", 128'(in_ready), 128'(0));
    check("zero_done_early", 128'(done), 128'(0));
    tick();
    check("zero_ready2", 128'(in_ready), 128'(0));
    check("zero_done", 128'(done), 128'(1));
    check("zero_sig", 128'(signature), 128'(32'hFFFFFFFF));
    check("zero_pass", 128'(pass), 128'(1));
    check("zero_cnt", 128'(vec_count), 128'(0));

    // Mismatch: all-ones folds to 03FFFFFF; FB3EE249 ^ 03FFFFFF = F8C11DB6.
    do_start(16'd1, 32'hFB3EE249);
    in_valid = 1'b1;
    in_y     = '1;
    tick();
    in_valid = 1'b0;
    wait_done("mis", 10);
    check("mis_sig", 128'(signature), 128'(32'hF8C11DB6));
    check("mis_done", 128'(done), 128'(1));
    check("mis_pass", 128'(pass), 128'(0));

    // Gapped valid pattern.
    do_start(16'd4, 32'h0);
    model   = 32'hFFFFFFFF;
    accepts = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = (gap_pat[i] != 0);
      in_y     = gap_vals[i];
      if (in_valid && in_ready) begin
        model = model_step(model, gap_vals[i]);
        accepts++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("gap_accepts", 128'(accepts), 128'(4));
    check("gap_ready_off", 128'(in_ready), 128'(0));
    check("gap_cnt", 128'(vec_count), 128'(4));
    check("gap_sig", 128'(signature), 128'(model));
    wait_done("gap", 10);
    check("gap_done", 128'(done), 128'(1));

    // Mid-run reset after 3 of 5 accepts; start during RUN is ignored.
    do_start(16'd5, 32'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_y = gap_vals[i];
      tick();
    end
    in_valid = 1'b0;
    do_start(16'd0, 32'h0);
    check("ign_cnt", 128'(vec_count), 128'(3));
    check("ign_busy", 128'(busy), 128'(1));
    check("ign_ready", 128'(in_ready), 128'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_cnt", 128'(vec_count), 128'(0));
    check("mid_busy", 128'(busy), 128'(0));
    check("mid_ready", 128'(in_ready), 128'(0));
    ya = gap_vals[4];
    yb = gap_vals[6];
    model = model_step(model_step(32'hFFFFFFFF, ya), yb);
    do_start(16'd2, model);
    in_valid = 1'b1;
    in_y     = ya;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_y     = yb;
    tick();
    in_valid = 1'b0;
    wait_done("restart", 10);
    check("restart_sig", 128'(signature), 128'(model));
    check("restart_cnt", 128'(vec_count), 128'(2));
    check("restart_pass", 128'(pass), 128'(1));
`ifdef EXPR_RESULT_CAPTURE_EN
    check("restart_first_y", 128'(first_y), 128'(ya));
    check("restart_last_y", 128'(last_y), 128'(yb));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
